// File: rtl/alu_arbiter.sv
// Two-port valid/ready front end for one shared 32-bit ALU: one grant per cycle, round-robin or fixed priority.
// Result is registered per port one cycle after grant; a full response slot blocks only its own port.
module alu_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [31:0] req_A0,
  input  logic [31:0] req_A1,
  input  logic [31:0] req_B0,
  input  logic [31:0] req_B1,
  input  logic [2:0]  req_control0,
  input  logic [2:0]  req_control1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_out0,
  output logic [31:0] rsp_out1,
  output logic [2:0]  rsp_flags0,
  output logic [2:0]  rsp_flags1,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_negative
);

  logic        elig0, elig1, prefer0, grant0, grant1;
  logic        last_grant_q, last_grant_d;
  logic        rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic [31:0] rsp_out0_q, rsp_out0_d, rsp_out1_q, rsp_out1_d;
  logic [2:0]  rsp_flags0_q, rsp_flags0_d, rsp_flags1_q, rsp_flags1_d;
  logic [2:0]  alu_flags;

  assign alu_flags = {alu_overflow, alu_zero, alu_negative};

  // A slot being drained this cycle is free, so the client can refill it immediately.
  always_comb begin
    elig0   = req_valid0 & (~rsp_valid0_q | rsp_ready0);
    elig1   = req_valid1 & (~rsp_valid1_q | rsp_ready1);
    prefer0 = FIXED_PRIORITY | last_grant_q;
    grant0  = elig0 & (~elig1 | prefer0);
    grant1  = elig1 & ~grant0;
  end

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;

  always_comb begin
    alu_A       = 32'd0;
    alu_B       = 32'd0;
    alu_control = 3'b010;
    if (grant0) begin
      alu_A       = req_A0;
      alu_B       = req_B0;
      alu_control = req_control0;
    end else if (grant1) begin
      alu_A       = req_A1;
      alu_B       = req_B1;
      alu_control = req_control1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0 | grant1) begin
      last_grant_d = grant1;
    end

    rsp_valid0_d = rsp_valid0_q;
    rsp_out0_d   = rsp_out0_q;
    rsp_flags0_d = rsp_flags0_q;
    if (grant0) begin
      rsp_valid0_d = 1'b1;
      rsp_out0_d   = alu_out;
      rsp_flags0_d = alu_flags;
    end else if (rsp_ready0 & rsp_valid0_q) begin
      rsp_valid0_d = 1'b0;
    end

    rsp_valid1_d = rsp_valid1_q;
    rsp_out1_d   = rsp_out1_q;
    rsp_flags1_d = rsp_flags1_q;
    if (grant1) begin
      rsp_valid1_d = 1'b1;
      rsp_out1_d   = alu_out;
      rsp_flags1_d = alu_flags;
    end else if (rsp_ready1 & rsp_valid1_q) begin
      rsp_valid1_d = 1'b0;
    end
  end

  // last_grant resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rsp_valid0_q <= 1'b0;
      rsp_out0_q   <= 32'd0;
      rsp_flags0_q <= 3'b000;
      rsp_valid1_q <= 1'b0;
      rsp_out1_q   <= 32'd0;
      rsp_flags1_q <= 3'b000;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_out0_q   <= rsp_out0_d;
      rsp_flags0_q <= rsp_flags0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_out1_q   <= rsp_out1_d;
      rsp_flags1_q <= rsp_flags1_d;
    end
  end

  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_out0   = rsp_out0_q;
  assign rsp_flags0 = rsp_flags0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_out1   = rsp_out1_q;
  assign rsp_flags1 = rsp_flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin instance driven from a vector table plus hand sequences,
// a fixed-priority instance for the priority case, and a per-port response scoreboard.
module tb_alu_arbiter;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] AND = 3'b100;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference ALU: returns {overflow, zero, negative, result}.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (c)
      3'b010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b011: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = ~(a | b);
      3'b111: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {ov, (r == 32'd0), r[31], r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin DUT
  logic        reset, req_valid0, req_valid1, req_ready0, req_ready1;
  logic [31:0] req_A0, req_A1, req_B0, req_B1;
  logic [2:0]  req_control0, req_control1;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] rsp_out0, rsp_out1;
  logic [2:0]  rsp_flags0, rsp_flags1;
  logic [31:0] alu_A, alu_B, alu_out;
  logic [2:0]  alu_control;
  logic        alu_overflow, alu_zero, alu_negative;

  assign {alu_overflow, alu_zero, alu_negative, alu_out} = alu_model(alu_A, alu_B, alu_control);

  alu_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
    .clock(clock), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_A0(req_A0), .req_A1(req_A1), .req_B0(req_B0), .req_B1(req_B1),
    .req_control0(req_control0), .req_control1(req_control1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_out0(rsp_out0), .rsp_out1(rsp_out1),
    .rsp_flags0(rsp_flags0), .rsp_flags1(rsp_flags1),
    .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .alu_negative(alu_negative)
  );

  // Fixed-priority DUT
  logic        f_reset, f_req_valid0, f_req_valid1, f_req_ready0, f_req_ready1;
  logic        f_rsp_valid0, f_rsp_valid1, f_rsp_ready0, f_rsp_ready1;
  logic [31:0] f_rsp_out0, f_rsp_out1, f_alu_A, f_alu_B, f_alu_out;
  logic [2:0]  f_rsp_flags0, f_rsp_flags1, f_alu_control;
  logic        f_alu_overflow, f_alu_zero, f_alu_negative;

  assign {f_alu_overflow, f_alu_zero, f_alu_negative, f_alu_out} =
      alu_model(f_alu_A, f_alu_B, f_alu_control);

  alu_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
    .clock(clock), .reset(f_reset),
    .req_valid0(f_req_valid0), .req_valid1(f_req_valid1),
    .req_ready0(f_req_ready0), .req_ready1(f_req_ready1),
    .req_A0(32'd1), .req_A1(32'd2), .req_B0(32'd3), .req_B1(32'd4),
    .req_control0(ADD), .req_control1(ADD),
    .rsp_valid0(f_rsp_valid0), .rsp_valid1(f_rsp_valid1),
    .rsp_ready0(f_rsp_ready0), .rsp_ready1(f_rsp_ready1),
    .rsp_out0(f_rsp_out0), .rsp_out1(f_rsp_out1),
    .rsp_flags0(f_rsp_flags0), .rsp_flags1(f_rsp_flags1),
    .alu_A(f_alu_A), .alu_B(f_alu_B), .alu_control(f_alu_control),
    .alu_out(f_alu_out), .alu_overflow(f_alu_overflow), .alu_zero(f_alu_zero),
    .alu_negative(f_alu_negative)
  );

  // Scoreboard: expected response pushed when a grant is seen, popped one cycle later.
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  bit          pg0 = 1'b0;
  bit          pg1 = 1'b0;

  always @(negedge clock) begin
    logic [34:0] e;
    if (pg0) begin
      if (q0.size() == 0) begin
        chk("sb0_empty", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        chk("sb_rsp0", {28'd0, rsp_valid0, rsp_flags0, rsp_out0}, {28'd0, 1'b1, e});
      end
    end
    if (pg1) begin
      if (q1.size() == 0) begin
        chk("sb1_empty", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        chk("sb_rsp1", {28'd0, rsp_valid1, rsp_flags1, rsp_out1}, {28'd0, 1'b1, e});
      end
    end
    if (reset) begin
      q0.delete();
      q1.delete();
      pg0 = 1'b0;
      pg1 = 1'b0;
    end else begin
      pg0 = req_ready0;
      pg1 = req_ready1;
      if (req_ready0) q0.push_back(alu_model(req_A0, req_B0, req_control0));
      if (req_ready1) q1.push_back(alu_model(req_A1, req_B1, req_control1));
    end
  end

  typedef struct {
    bit          rst, v0, v1, rr0, rr1;
    logic [31:0] a0, b0;
    logic [2:0]  c0;
    logic [31:0] a1, b1;
    logic [2:0]  c1;
    bit          g0, g1, rv0, rv1;
  } vec_t;

  vec_t tbl[11];

  task automatic drive(input vec_t r);
    reset        = r.rst;
    req_valid0   = r.v0;
    req_valid1   = r.v1;
    rsp_ready0   = r.rr0;
    rsp_ready1   = r.rr1;
    req_A0       = r.a0;
    req_B0       = r.b0;
    req_control0 = r.c0;
    req_A1       = r.a1;
    req_B1       = r.b1;
    req_control1 = r.c1;
  endtask

  task automatic apply_row(input int i);
    drive(tbl[i]);
    @(negedge clock);
    chk($sformatf("row%0d_grant0", i), {63'd0, req_ready0}, {63'd0, tbl[i].g0});
    chk($sformatf("row%0d_grant1", i), {63'd0, req_ready1}, {63'd0, tbl[i].g1});
    chk($sformatf("row%0d_rsp_valid", i), {62'd0, rsp_valid0, rsp_valid1},
        {62'd0, tbl[i].rv0, tbl[i].rv1});
    if (!tbl[i].g0 && !tbl[i].g1) begin
      chk($sformatf("row%0d_idle_drive", i), {alu_A, alu_B[28:0], alu_control},
          {32'd0, 29'd0, ADD});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    //          rst v0 v1 rr0 rr1  a0      b0     c0    a1            b1            c1   g0 g1 rv0 rv1
    tbl[0]  = '{0, 1, 0, 1, 0, 32'd5, 32'd7, ADD, 32'd0,        32'd0,        ADD, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 32'd0, 32'd0, ADD, 32'd0,        32'd0,        ADD, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 1, 32'd0, 32'd0, ADD, 32'd0,        32'd0,        ADD, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 32'd0, 32'd0, ADD, 32'd0,        32'd0,        ADD, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 1, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 1, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 0, 1, 1, 0};
    tbl[6]  = '{0, 1, 1, 1, 1, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 1, 0, 0, 1};
    tbl[7]  = '{0, 1, 1, 1, 1, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 0, 1, 1, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 1, 1, 0, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 1, 0, 1, 1};
    tbl[10] = '{0, 1, 1, 1, 0, 32'd3, 32'd3, SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, SUB, 1, 0, 1, 1};

    drive('{1, 0, 0, 0, 0, 32'd0, 32'd0, ADD, 32'd0, 32'd0, ADD, 0, 0, 0, 0});
    f_reset = 1'b1; f_req_valid0 = 1'b0; f_req_valid1 = 1'b0;
    f_rsp_ready0 = 1'b0; f_rsp_ready1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset_state_rr", {rsp_valid0, rsp_valid1, rsp_flags0, rsp_flags1, rsp_out0[23:0], rsp_out1[23:0]}, 64'd0);
    chk("reset_state_fp", {f_rsp_valid0, f_rsp_valid1, f_rsp_out0, f_rsp_flags0}, 64'd0);
    @(posedge clock);
    #1;

    // Single port ADD 5+7, drained, then idle: response register holds its data.
    for (int i = 0; i < 2; i++) apply_row(i);
    chk("single_out0_held", {29'd0, rsp_flags0, rsp_out0}, {29'd0, 3'b000, 32'd12});
    chk("port1_idle", {63'd0, rsp_valid1}, 64'd0);
    apply_row(2);
    chk("idle_no_change", {28'd0, rsp_valid0, rsp_flags0, rsp_out0}, {28'd0, 1'b0, 3'b000, 32'd12});

    // Reset, contention 0,1,0,1, then port 1 backpressure.
    for (int i = 3; i < 11; i++) apply_row(i);
    chk("bp_out1_stable", {29'd0, rsp_flags1, rsp_out1}, {29'd0, 3'b101, 32'h80000000});

    // Drain-and-refill on port 1 with a different op.
    req_A1 = 32'h0000F0F0; req_B1 = 32'h0000FF00; req_control1 = AND; rsp_ready1 = 1'b1;
    @(negedge clock);
    chk("refill_grant", {62'd0, req_ready0, req_ready1}, {62'd0, 2'b01});
    @(posedge clock);
    #1;
    chk("refill_rsp1", {28'd0, rsp_valid1, rsp_flags1, rsp_out1}, {28'd0, 1'b1, 3'b000, 32'h0000F000});

    // Fill both slots, then reset while port 0 has a drain-refill grant pending.
    req_A0 = 32'd5; req_B0 = 32'd7; req_control0 = ADD;
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    @(posedge clock);
    #1;
    rsp_ready0 = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    chk("pre_reset_full", {62'd0, rsp_valid0, rsp_valid1}, {62'd0, 2'b11});
    chk("pre_reset_grant", {62'd0, req_ready0, req_ready1}, {62'd0, 2'b10});
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_reset_clear", {rsp_valid0, rsp_valid1, rsp_flags0, rsp_flags1, rsp_out0[23:0], rsp_out1[23:0]}, 64'd0);
    chk("mid_reset_out", {rsp_out0, rsp_out1}, 64'd0);
    rsp_ready1 = 1'b1;
    @(negedge clock);
    chk("post_reset_contention", {62'd0, req_ready0, req_ready1}, {62'd0, 2'b10});
    @(posedge clock);
    #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;

    // Fixed priority: port 0 wins every contention.
    f_reset = 1'b0;
    f_req_valid0 = 1'b1; f_req_valid1 = 1'b1;
    f_rsp_ready0 = 1'b1; f_rsp_ready1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("fp_grant_%0d", k), {62'd0, f_req_ready0, f_req_ready1}, {62'd0, 2'b10});
      @(posedge clock);
      #1;
    end
    f_req_valid0 = 1'b0; f_req_valid1 = 1'b0;
    chk("fp_rsp0", {28'd0, f_rsp_valid0, f_rsp_flags0, f_rsp_out0}, {28'd0, 1'b1, 3'b000, 32'd4});
    chk("fp_rsp1_empty", {63'd0, f_rsp_valid1}, 64'd0);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
